// File: rtl/id_ex_ctrl.sv
// id_ex_ctrl: decode-to-execute control pipeline register of the MIPS core.
// Captures the decoder control word and register specifiers into E, resolves
// the destination register, detects load-use hazards and inserts bubbles on
// hazard or flush, holding E while execute applies back-pressure.
// Optional build macro ID_EX_PERF_EN adds saturating stall/bubble counters.
module id_ex_ctrl #(
    parameter int REGW   = 5,
    parameter int ALUOPW = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_d,
    input  logic              regwrite_d,
    input  logic              regdst_d,
    input  logic              alusrc_d,
    input  logic              branch_d,
    input  logic              memwrite_d,
    input  logic              memtoreg_d,
    input  logic              jump_d,
    input  logic [ALUOPW-1:0] aluop_d,
    input  logic [REGW-1:0]   rs_d,
    input  logic [REGW-1:0]   rt_d,
    input  logic [REGW-1:0]   rd_d,
    input  logic              flush_e,
    input  logic              ex_ready,
    output logic              valid_e,
    output logic              regwrite_e,
    output logic              alusrc_e,
    output logic              branch_e,
    output logic              memwrite_e,
    output logic              memtoreg_e,
    output logic              jump_e,
    output logic [ALUOPW-1:0] aluop_e,
    output logic [REGW-1:0]   rs_e,
    output logic [REGW-1:0]   rt_e,
    output logic [REGW-1:0]   writereg_e,
    output logic              stall_d
`ifdef ID_EX_PERF_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       bubble_cnt
`endif
);

    // Control word layout: {regwrite, alusrc, branch, memwrite, memtoreg, jump, aluop}
    localparam int CW = 6 + ALUOPW;

    logic [CW-1:0]   ctrl_d;
    logic [CW-1:0]   ctrl_reg, ctrl_next;
    logic            valid_reg, valid_next;
    logic [REGW-1:0] rs_reg, rs_next;
    logic [REGW-1:0] rt_reg, rt_next;
    logic [REGW-1:0] wr_reg, wr_next;
    logic            hazard;
    logic            load_bubble;

    assign ctrl_d = {regwrite_d, alusrc_d, branch_d, memwrite_d, memtoreg_d, jump_d, aluop_d};

    assign {regwrite_e, alusrc_e, branch_e, memwrite_e, memtoreg_e, jump_e, aluop_e} = ctrl_reg;
    assign valid_e    = valid_reg;
    assign rs_e       = rs_reg;
    assign rt_e       = rt_reg;
    assign writereg_e = wr_reg;

    // A load in E whose destination (non-zero) is read by the instruction in D.
    assign hazard = valid_reg && memtoreg_e && (rt_reg != '0) && valid_d &&
                    ((rt_reg == rs_d) || (rt_reg == rt_d));

    assign stall_d = hazard || !ex_ready;

    // Flush beats back-pressure; a hazard bubble only happens when E can advance.
    assign load_bubble = flush_e || (ex_ready && hazard);

    // Next-state selection for the E registers: bubble, hold, or load from D.
    always_comb begin
        valid_next = valid_reg;
        ctrl_next  = ctrl_reg;
        rs_next    = rs_reg;
        rt_next    = rt_reg;
        wr_next    = wr_reg;
        if (load_bubble) begin
            valid_next = 1'b0;
            ctrl_next  = '0;
            rs_next    = '0;
            rt_next    = '0;
            wr_next    = '0;
        end else if (ex_ready) begin
            // An empty decode slot still carries its fields but no side effects.
            valid_next = valid_d;
            ctrl_next  = valid_d ? ctrl_d : '0;
            rs_next    = rs_d;
            rt_next    = rt_d;
            wr_next    = regdst_d ? rd_d : rt_d;
        end
    end

    // E stage registers, cleared immediately by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_reg <= 1'b0;
            ctrl_reg  <= '0;
            rs_reg    <= '0;
            rt_reg    <= '0;
            wr_reg    <= '0;
        end else begin
            valid_reg <= valid_next;
            ctrl_reg  <= ctrl_next;
            rs_reg    <= rs_next;
            rt_reg    <= rt_next;
            wr_reg    <= wr_next;
        end
    end

`ifdef ID_EX_PERF_EN
    logic [15:0] stall_cnt_reg;
    logic [15:0] bubble_cnt_reg;

    assign stall_cnt  = stall_cnt_reg;
    assign bubble_cnt = bubble_cnt_reg;

    // Saturating count of edges on which decode was told to hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_reg <= '0;
        end else if (stall_d && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    // Saturating count of edges on which a bubble entered E.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_cnt_reg <= '0;
        end else if (load_bubble && (bubble_cnt_reg != 16'hFFFF)) begin
            bubble_cnt_reg <= bubble_cnt_reg + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_ctrl.sv
// Self-checking bench for id_ex_ctrl: reset checks, a directed vector table,
// hand-written async-reset and hazard sequences, then randomized stimulus
// against a reference model of the E stage.
module tb_id_ex_ctrl;

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       regdst;
        logic       alusrc;
        logic       branch;
        logic       memwrite;
        logic       memtoreg;
        logic       jump;
        logic [1:0] aluop;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } din_t;

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       alusrc;
        logic       branch;
        logic       memwrite;
        logic       memtoreg;
        logic       jump;
        logic [1:0] aluop;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] wr;
    } e_t;

    typedef struct {
        din_t d;
        logic fl;
        logic rdy;
        logic exp_stall;
        e_t   exp_e;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       valid_d = 1'b0;
    logic       regwrite_d = 1'b0, regdst_d = 1'b0, alusrc_d = 1'b0, branch_d = 1'b0;
    logic       memwrite_d = 1'b0, memtoreg_d = 1'b0, jump_d = 1'b0;
    logic [1:0] aluop_d = '0;
    logic [4:0] rs_d = '0, rt_d = '0, rd_d = '0;
    logic       flush_e = 1'b0;
    logic       ex_ready = 1'b1;
    logic       valid_e, regwrite_e, alusrc_e, branch_e, memwrite_e, memtoreg_e, jump_e;
    logic [1:0] aluop_e;
    logic [4:0] rs_e, rt_e, writereg_e;
    logic       stall_d;
`ifdef ID_EX_PERF_EN
    logic [15:0] stall_cnt, bubble_cnt;
`endif

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    id_ex_ctrl #(.REGW(5), .ALUOPW(2)) dut (
        .clk(clk), .reset(reset), .valid_d(valid_d),
        .regwrite_d(regwrite_d), .regdst_d(regdst_d), .alusrc_d(alusrc_d),
        .branch_d(branch_d), .memwrite_d(memwrite_d), .memtoreg_d(memtoreg_d),
        .jump_d(jump_d), .aluop_d(aluop_d), .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
        .flush_e(flush_e), .ex_ready(ex_ready), .valid_e(valid_e),
        .regwrite_e(regwrite_e), .alusrc_e(alusrc_e), .branch_e(branch_e),
        .memwrite_e(memwrite_e), .memtoreg_e(memtoreg_e), .jump_e(jump_e),
        .aluop_e(aluop_e), .rs_e(rs_e), .rt_e(rt_e), .writereg_e(writereg_e),
        .stall_d(stall_d)
`ifdef ID_EX_PERF_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    // ---------------- stimulus builders ----------------
    function automatic din_t rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        din_t d = '0;
        d.valid = 1; d.regwrite = 1; d.regdst = 1; d.aluop = 2'b10;
        d.rs = rs; d.rt = rt; d.rd = rd;
        return d;
    endfunction

    function automatic din_t lw(input logic [4:0] rs, input logic [4:0] rt);
        din_t d = '0;
        d.valid = 1; d.regwrite = 1; d.alusrc = 1; d.memtoreg = 1;
        d.rs = rs; d.rt = rt; d.rd = 5'd31;
        return d;
    endfunction

    function automatic din_t sw(input logic [4:0] rs, input logic [4:0] rt);
        din_t d = '0;
        d.valid = 1; d.alusrc = 1; d.memwrite = 1; d.rs = rs; d.rt = rt;
        return d;
    endfunction

    function automatic din_t beq(input logic [4:0] rs, input logic [4:0] rt);
        din_t d = '0;
        d.valid = 1; d.branch = 1; d.aluop = 2'b01; d.rs = rs; d.rt = rt;
        return d;
    endfunction

    function automatic e_t ew(input logic v, input logic rw, input logic as, input logic br,
                              input logic mw, input logic mtr, input logic j,
                              input logic [1:0] op, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [4:0] wr);
        return {v, rw, as, br, mw, mtr, j, op, rs, rt, wr};
    endfunction

    task automatic add_vec(input din_t d, input logic fl, input logic rdy,
                           input logic st, input e_t e);
        vec_t v;
        v.d = d; v.fl = fl; v.rdy = rdy; v.exp_stall = st; v.exp_e = e;
        vecs.push_back(v);
    endtask

    // ---------------- reference model ----------------
    function automatic logic model_hazard(input e_t cur, input din_t d);
        return cur.valid && cur.memtoreg && (cur.rt != 0) && d.valid &&
               ((cur.rt == d.rs) || (cur.rt == d.rt));
    endfunction

    function automatic e_t model_next(input e_t cur, input din_t d, input logic fl, input logic rdy);
        e_t n;
        if (fl) return '0;
        if (!rdy) return cur;
        if (model_hazard(cur, d)) return '0;
        n.valid    = d.valid;
        n.regwrite = d.valid & d.regwrite;
        n.alusrc   = d.valid & d.alusrc;
        n.branch   = d.valid & d.branch;
        n.memwrite = d.valid & d.memwrite;
        n.memtoreg = d.valid & d.memtoreg;
        n.jump     = d.valid & d.jump;
        n.aluop    = d.valid ? d.aluop : 2'b00;
        n.rs       = d.rs;
        n.rt       = d.rt;
        n.wr       = d.regdst ? d.rd : d.rt;
        return n;
    endfunction

    // ---------------- DUT access and checks ----------------
    function automatic e_t dut_e();
        return {valid_e, regwrite_e, alusrc_e, branch_e, memwrite_e, memtoreg_e,
                jump_e, aluop_e, rs_e, rt_e, writereg_e};
    endfunction

    task automatic drive(input din_t d, input logic fl, input logic rdy);
        valid_d = d.valid; regwrite_d = d.regwrite; regdst_d = d.regdst;
        alusrc_d = d.alusrc; branch_d = d.branch; memwrite_d = d.memwrite;
        memtoreg_d = d.memtoreg; jump_d = d.jump; aluop_d = d.aluop;
        rs_d = d.rs; rt_d = d.rt; rd_d = d.rd;
        flush_e = fl; ex_ready = rdy;
    endtask

    task automatic check_e(input string name, input e_t exp);
        e_t act = dut_e();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: E word got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Applies one vector: stall_d is judged before the edge, E after it.
    task automatic run_vec(input string name, input vec_t v);
        drive(v.d, v.fl, v.rdy);
        @(negedge clk);
        check_val({name, "_stall"}, {15'd0, stall_d}, {15'd0, v.exp_stall});
        @(posedge clk);
        #1;
        check_e({name, "_e"}, v.exp_e);
        $display("txn %s fl=%0b rdy=%0b stall=%0b E=%h", name, v.fl, v.rdy, v.exp_stall, dut_e());
    endtask

    // Releases reset away from the clock edge and loads one empty slot.
    task automatic release_reset();
        drive('0, 1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        e_t   m_e;
        e_t   m_nxt;
        din_t rd;
        logic rfl, rrdy, m_stall;
        int   m_stall_cnt, m_bubble_cnt;

        // ---------- reset state ----------
        drive('0, 1'b0, 1'b1);
        #12;
        check_e("reset_e", '0);
        check_val("reset_stall_ready", {15'd0, stall_d}, 16'd0);
        ex_ready = 1'b0;
        #1;
        check_val("reset_stall_notready", {15'd0, stall_d}, 16'd1);
        release_reset();
        check_e("post_reset_idle", '0);

        // ---------- directed vector table ----------
        add_vec(rtype(1, 2, 3),  0, 1, 0, ew(1,1,0,0,0,0,0,2'b10, 1, 2, 3));
        add_vec(lw(4, 8),        0, 1, 0, ew(1,1,1,0,0,1,0,2'b00, 4, 8, 8));
        add_vec(rtype(8, 9, 10), 0, 1, 1, '0);
        add_vec(rtype(8, 9, 10), 0, 1, 0, ew(1,1,0,0,0,0,0,2'b10, 8, 9, 10));
        add_vec(lw(1, 0),        0, 1, 0, ew(1,1,1,0,0,1,0,2'b00, 1, 0, 0));
        add_vec(rtype(0, 0, 5),  0, 1, 0, ew(1,1,0,0,0,0,0,2'b10, 0, 0, 5));
        add_vec(sw(2, 3),        1, 1, 0, '0);
        add_vec(beq(4, 5),       0, 1, 0, ew(1,0,0,1,0,0,0,2'b01, 4, 5, 5));
        add_vec(rtype(6, 7, 11), 0, 0, 1, ew(1,0,0,1,0,0,0,2'b01, 4, 5, 5));
        add_vec(rtype(6, 7, 11), 0, 0, 1, ew(1,0,0,1,0,0,0,2'b01, 4, 5, 5));
        add_vec(rtype(6, 7, 11), 0, 0, 1, ew(1,0,0,1,0,0,0,2'b01, 4, 5, 5));
        add_vec(rtype(6, 7, 11), 0, 1, 0, ew(1,1,0,0,0,0,0,2'b10, 6, 7, 11));
        rd = rtype(12, 13, 14);
        rd.valid = 0; rd.memwrite = 1; rd.jump = 1; rd.branch = 1;
        add_vec(rd,              0, 1, 0, ew(0,0,0,0,0,0,0,2'b00, 12, 13, 14));
        add_vec(rtype(1, 2, 3),  1, 0, 1, '0);
        add_vec(lw(0, 20),       0, 1, 0, ew(1,1,1,0,0,1,0,2'b00, 0, 20, 20));
        add_vec(rtype(1, 20, 21),0, 0, 1, ew(1,1,1,0,0,1,0,2'b00, 0, 20, 20));
        add_vec(rtype(1, 20, 21),0, 1, 1, '0);
        add_vec(rtype(1, 20, 21),0, 1, 0, ew(1,1,0,0,0,0,0,2'b10, 1, 20, 21));

        foreach (vecs[i]) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // ---------- asynchronous reset between edges ----------
        drive(rtype(1, 2, 3), 1'b0, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check_e("async_reset_e", '0);
        check_val("async_reset_stall", {15'd0, stall_d}, 16'd0);
        $display("txn async_reset E=%h", dut_e());
        @(posedge clk);
        #1;
        check_e("async_reset_held", '0);
        release_reset();

        // ---------- load-use hazard sequence (also feeds the counters) ----------
        vecs.delete();
        add_vec(lw(0, 8),        0, 1, 0, ew(1,1,1,0,0,1,0,2'b00, 0, 8, 8));
        add_vec(rtype(8, 9, 10), 0, 1, 1, '0);
        add_vec(rtype(8, 9, 10), 0, 1, 0, ew(1,1,0,0,0,0,0,2'b10, 8, 9, 10));
        foreach (vecs[i]) begin
            run_vec($sformatf("hazseq%0d", i), vecs[i]);
        end
`ifdef ID_EX_PERF_EN
        check_val("perf_stall_cnt", stall_cnt, 16'd1);
        check_val("perf_bubble_cnt", bubble_cnt, 16'd1);
`endif

        // ---------- randomized run against the model ----------
        reset = 1'b0;
        #1;
        release_reset();
        m_e = '0;
        m_stall_cnt = 0;
        m_bubble_cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            rd = din_t'($urandom);
            rd.valid = ($urandom_range(0, 7) != 0);
            rd.memtoreg = ($urandom_range(0, 2) == 0);
            rd.rs = 5'($urandom_range(0, 3));
            rd.rt = 5'($urandom_range(0, 3));
            rfl = ($urandom_range(0, 9) == 0);
            rrdy = ($urandom_range(0, 3) != 0);
            drive(rd, rfl, rrdy);
            @(negedge clk);
            m_stall = model_hazard(m_e, rd) || !rrdy;
            check_val($sformatf("rand%0d_stall", n), {15'd0, stall_d}, {15'd0, m_stall});
            m_nxt = model_next(m_e, rd, rfl, rrdy);
            if (m_stall && m_stall_cnt < 16'hFFFF) m_stall_cnt++;
            if ((rfl || (rrdy && model_hazard(m_e, rd))) && m_bubble_cnt < 16'hFFFF) m_bubble_cnt++;
            @(posedge clk);
            #1;
            m_e = m_nxt;
            check_e($sformatf("rand%0d", n), m_e);
`ifdef ID_EX_PERF_EN
            check_val($sformatf("rand%0d_stall_cnt", n), stall_cnt, 16'(m_stall_cnt));
            check_val($sformatf("rand%0d_bubble_cnt", n), bubble_cnt, 16'(m_bubble_cnt));
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_ctrl.md
Name: id_ex_ctrl

Overview:
- Decode-to-execute control pipeline stage of the pipelined MIPS core.
- Sits directly downstream of the main decoder. Registers its control word plus register specifiers into the E stage.
- Resolves the destination register and detects load-use hazards.
- Stalls decode and inserts bubbles on hazard, flush or execute back-pressure.

Parameters:
- REGW, 5, register specifier width
- ALUOPW, 2, aluop width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- valid_d  in  1  decode holds a real instruction
- regwrite_d, regdst_d, alusrc_d, branch_d, memwrite_d, memtoreg_d, jump_d  in  1 each  decoder control outputs
- aluop_d  in  ALUOPW  decoder aluop
- rs_d, rt_d, rd_d  in  REGW  instruction fields
- flush_e  in  1  kill the instruction entering E this cycle
- ex_ready  in  1  execute stage can accept a new instruction
- valid_e  out  1  E holds a real instruction
- regwrite_e, alusrc_e, branch_e, memwrite_e, memtoreg_e, jump_e  out  1 each  registered controls
- aluop_e  out  ALUOPW  registered aluop
- rs_e, rt_e  out  REGW  registered sources
- writereg_e  out  REGW  destination: rd_d if regdst_d=1, else rt_d, captured at load
- stall_d  out  1  combinational; decode/fetch must hold their registers

Behaviour:
- Reset (reset=0, asynchronous): all registered outputs are 0. valid_e=0. The E stage is a bubble, so stall_d=0 unless ex_ready=0.
- Hazard (combinational): hazard = valid_e & memtoreg_e & (rt_e != 0) & valid_d & ((rt_e == rs_d) | (rt_e == rt_d)).
- stall_d = hazard | ~ex_ready.
- Per-edge action, priority high to low:
  1. flush_e=1: load bubble.
  2. ex_ready=0: hold all E registers unchanged.
  3. hazard=1: load bubble.
  4. otherwise: load the D-stage values, with valid_e <= valid_d.
- Bubble: valid_e=0, and every control output (regwrite, memwrite, branch, jump, memtoreg, alusrc, aluop) is 0. rs_e, rt_e and writereg_e are 0.
- When valid_d=0, the load step still captures the fields, but all controls are forced to 0. No side-effecting control may be set while valid_e=0.
- Latency: one cycle from D inputs to E outputs. Throughput: one instruction per cycle with no hazards.
- Simultaneous flush_e and ex_ready=0: flush wins and E becomes a bubble. stall_d is still 1 because ex_ready=0.
- Simultaneous hazard and ex_ready=0: hold. The load keeps its place in E, and stall_d=1.
- A load-use hazard produces exactly one bubble. After the bubble, the load has left E, so hazard=0 next cycle (assuming ex_ready=1).
- Register 0 never causes a hazard.
- Reset asserted mid-operation clears E immediately, without waiting for a clock edge.
- Upstream flushing of decode is not this block's responsibility.

Optional Feature:
- Macro: ID_EX_PERF_EN.
- Defined:
  - adds outputs stall_cnt[15:0] and bubble_cnt[15:0], both reset to 0.
  - stall_cnt increments on every edge where stall_d=1.
  - bubble_cnt increments on every edge where a bubble is loaded (flush or hazard).
  - both counters saturate at 16'hFFFF.
- Undefined: neither port nor counter exists, and the remaining behaviour is identical.

Test Plan:
- Reset, then an R-type (regwrite=1, regdst=1, aluop=2'b10, rs=1, rt=2, rd=3, valid_d=1) with ex_ready=1:
  - next edge: valid_e=1, regwrite_e=1, aluop_e=2'b10, writereg_e=3, stall_d=0.
- LW (memtoreg=1, alusrc=1, regwrite=1, rt=8) followed by ADD with rs_d=8:
  - cycle after the LW enters E: stall_d=1.
  - next edge: bubble (valid_e=0, regwrite_e=0).
  - following edge: ADD in E with rs_e=8, and stall_d=0.
- LW with rt=0 followed by a reader of $0 -> stall_d=0 and no bubble.
- SW in D with flush_e=1 -> next edge valid_e=0, memwrite_e=0.
- ex_ready=0 for 3 cycles while BEQ is in E:
  - E outputs stable, with branch_e=1 throughout.
  - stall_d=1 for all 3 cycles.
  - when ex_ready returns to 1, the next D instruction loads.
- reset driven low mid-stream between edges -> all outputs 0 immediately.
- With ID_EX_PERF_EN: the hazard scenario yields stall_cnt=1 and bubble_cnt=1.
